// File: rtl/mem_access_unit_if.sv
// Bus bundle between the CPU MEM stage, mem_access_unit and the
// word-addressed data_memory.
//
// Handshake: the CPU raises cpu_req and holds it, together with
// cpu_we/cpu_funct3/cpu_addr/cpu_wdata, until a clock edge where
// cpu_ready=1.  That edge accepts the request.  The result is reported by
// a one-cycle cpu_done pulse.  cpu_err and cpu_rdata are valid with
// cpu_done and stay stable until the next accept.
//
// Modports:
//   slave  - the access unit: takes CPU requests, drives the memory side.
//   master - the environment (CPU plus data_memory): issues requests and
//            returns mem_dout.
interface mem_access_unit_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, mem_dout,
        output cpu_ready, cpu_done, cpu_err, cpu_rdata,
        output mem_addr, mem_din, mem_read, mem_write
    );

    modport master (
        output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, mem_dout,
        input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
        input  mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end between the CPU MEM stage and a word-addressed
// data_memory (asynchronous read, synchronous write).  Handles RV32I
// byte/half/word loads with sign/zero extension and sub-word stores by
// read-modify-write.  Misaligned, illegal-funct3 and out-of-range accesses
// are reported as faults and never touch memory.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high
//   bus        mem_access_unit_if.slave (CPU request/response + memory side)
//   state_dbg  current FSM state (0 IDLE, 1 RD, 2 WR, 3 RESP)
//
// Latency from the accept edge to the cpu_done cycle:
//   load 2, SW 2, SB/SH 3, fault 1.
module mem_access_unit #(
    parameter int MEM_DEPTH = 16384
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_access_unit_if.slave        bus,
    output logic [1:0]              state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic [2:0]  funct3_q;
    logic        we_q, err_q;

    logic        accept, fault, f3_illegal, misaligned, out_of_range;
    logic [31:0] lane_b, lane_h, load_val, merged;

    // Request classification, evaluated on the live CPU inputs at accept.
    assign accept = (state == IDLE) && bus.cpu_req;

    always_comb begin
        if (bus.cpu_we)
            f3_illegal = (bus.cpu_funct3 > 3'b010);
        else
            f3_illegal = (bus.cpu_funct3 == 3'b011) || (bus.cpu_funct3[2:1] == 2'b11);
    end

    always_comb begin
        case (bus.cpu_funct3[1:0])
            2'b01:   misaligned = bus.cpu_addr[0];
            2'b10:   misaligned = (bus.cpu_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = ({2'b00, bus.cpu_addr[31:2]} >= 32'(MEM_DEPTH));
    assign fault        = f3_illegal || misaligned || out_of_range;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault)                           state_nxt = RESP;
                    else if (!bus.cpu_we)                state_nxt = RD;
                    else if (bus.cpu_funct3[1:0] == 2'b10) state_nxt = WR;
                    else                                 state_nxt = RD;  // SB/SH read first
                end
            end
            RD:      state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs.  Memory strobes are gated by reset so an aborted access
    // cannot write in the reset cycle.
    always_comb begin
        bus.cpu_ready = (state == IDLE);
        bus.cpu_done  = (state == RESP);
        bus.mem_read  = !reset && (state == RD);
        bus.mem_write = !reset && (state == WR);
        bus.mem_din   = (state == WR) ? merged : 32'd0;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.cpu_rdata = rdata_q;
        bus.cpu_err   = err_q;
        state_dbg     = state;
    end

    // Little-endian lane extraction for loads.
    always_comb begin
        lane_b = bus.mem_dout >> {addr_q[1:0], 3'b000};
        lane_h = bus.mem_dout >> {addr_q[1], 4'b0000};
        case (funct3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b[7:0]};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h[15:0]};
            3'b010:  load_val = bus.mem_dout;
            3'b100:  load_val = {24'd0, lane_b[7:0]};
            3'b101:  load_val = {16'd0, lane_h[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    // Store word: SW passes through, SB/SH patch one lane of the word read in RD.
    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Request and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            word_q   <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else if (accept) begin
            addr_q   <= bus.cpu_addr;
            wdata_q  <= bus.cpu_wdata;
            funct3_q <= bus.cpu_funct3;
            we_q     <= bus.cpu_we;
            rdata_q  <= 32'd0;
            err_q    <= fault;
        end else if (state == RD) begin
            word_q <= bus.mem_dout;
            if (!we_q) rdata_q <= load_val;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int MEM_DEPTH   = 16384;
    localparam int MODEL_WORDS = 32;

    typedef struct packed {
        logic        err;
        logic [2:0]  lat;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state_dbg;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if bus();

    mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- data_memory model ----------------
    logic [31:0] mem     [0:MODEL_WORDS-1];
    logic [31:0] ref_mem [0:MODEL_WORDS-1];
    logic        fill_en  = 1'b0;
    logic [4:0]  fill_idx = 5'd0;
    logic [31:0] fill_val = 32'd0;

    always @(posedge clk) begin
        if (fill_en)            mem[fill_idx] <= fill_val;
        else if (bus.mem_write) mem[bus.mem_addr[6:2]] <= bus.mem_din;
    end
    assign bus.mem_dout = mem[bus.mem_addr[6:2]];

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: RV32I load/store rules on a word array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        logic        legal, bad;
        logic [31:0] sz, old, v, mask, sh;
        int          w;
        e       = '0;
        e.addr  = a;
        legal   = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                        f3 == 3'd4 || f3 == 3'd5);
        sz      = 32'd1 << f3[1:0];
        bad     = !legal || ((a & (sz - 1)) != 0) || ((a >> 2) >= MEM_DEPTH);
        if (bad) begin
            e.err = 1'b1;
            e.lat = 3'd1;
            return;
        end
        w   = int'(a[6:2]);
        old = ref_mem[w];
        sh  = 32'd8 * a[1:0];
        if (!we) begin
            v     = old >> sh;
            e.lat = 3'd2;
            case (f3)
                3'd0: e.rdata = (v & 32'hFF)   - ((v & 32'h80)   << 1);
                3'd1: e.rdata = (v & 32'hFFFF) - ((v & 32'h8000) << 1);
                3'd4: e.rdata = v & 32'hFF;
                3'd5: e.rdata = v & 32'hFFFF;
                default: e.rdata = old;
            endcase
        end else begin
            mask       = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
            ref_mem[w] = (old & ~(mask << sh)) | ((wd & mask) << sh);
            e.lat      = (sz == 4) ? 3'd2 : 3'd3;
        end
    endtask

    // ---------------- monitor ----------------
    int   acc_cyc = 0;
    logic active  = 1'b0;
    exp_t cur     = '0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.cpu_done) begin
            active = 1'b0;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: cycle %0d, no request outstanding", cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.cpu_err !== e.err || bus.cpu_rdata !== e.rdata ||
                    (cyc - acc_cyc) != int'(e.lat)) begin
                    n_err++;
                    $display("FAIL response addr=%h: got err=%b rdata=%h lat=%0d, want err=%b rdata=%h lat=%0d",
                             e.addr, bus.cpu_err, bus.cpu_rdata, cyc - acc_cyc,
                             e.err, e.rdata, e.lat);
                end
            end
        end
        if (active && (bus.mem_read || bus.mem_write)) begin
            n_cmp++;
            if (cur.err || bus.mem_addr !== {cur.addr[31:2], 2'b00}) begin
                n_err++;
                $display("FAIL mem_access addr=%h: got mem_addr=%h rd=%b wr=%b, want no access on fault / mem_addr=%h",
                         cur.addr, bus.mem_addr, bus.mem_read, bus.mem_write,
                         {cur.addr[31:2], 2'b00});
            end
        end
        if (!reset && bus.cpu_ready && bus.cpu_req) begin
            acc_cyc = cyc;
            if (exp_q.size() > 0) begin
                cur    = exp_q[0];
                active = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.cpu_ready && t < 50);
        if (!bus.cpu_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: cpu_ready=0 after %0d cycles, want 1", t);
        end
    endtask

    // Issue one request; with hold=1 cpu_req stays high into the next call.
    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic hold);
        exp_t e;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = we;
        bus.cpu_funct3 = f3;
        bus.cpu_addr   = a;
        bus.cpu_wdata  = wd;
        model(we, f3, a, wd, e);
        exp_q.push_back(e);
        wait_ready();
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.cpu_req = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        rwe;
        logic [2:0]  rf3;
        logic [1:0]  low;
        logic [31:0] ra;
        int          t;

        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_funct3 = 3'd0;
        bus.cpu_addr   = 32'd0;
        bus.cpu_wdata  = 32'd0;

        // Fill memory and model with random words while reset is held.
        for (int i = 0; i < MODEL_WORDS; i++) begin
            fill_val    = $urandom;
            fill_idx    = 5'(i);
            ref_mem[i]  = fill_val;
            fill_en     = 1'b1;
            @(posedge clk);
            #1;
        end
        fill_en = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(bus.cpu_ready), 32'd1);
        check("reset_done", 32'(bus.cpu_done), 32'd0);
        check("reset_err", 32'(bus.cpu_err), 32'd0);
        check("reset_rdata", bus.cpu_rdata, 32'd0);
        check("reset_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;

        // Directed word, byte and half accesses.
        op(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        op(0, 3'b010, 32'h10, 32'h0, 0);
        op(1, 3'b000, 32'h12, 32'h55, 0);
        op(0, 3'b010, 32'h10, 32'h0, 0);
        op(0, 3'b000, 32'h12, 32'h0, 0);
        op(0, 3'b100, 32'h13, 32'h0, 0);
        op(0, 3'b000, 32'h13, 32'h0, 0);
        op(1, 3'b001, 32'h12, 32'h8001, 0);
        op(0, 3'b001, 32'h12, 32'h0, 0);
        op(0, 3'b101, 32'h12, 32'h0, 0);
        op(0, 3'b010, 32'h10, 32'h0, 0);

        // Faults.
        op(0, 3'b010, 32'h11, 32'h0, 0);
        op(0, 3'b001, 32'h13, 32'h0, 0);
        op(0, 3'b011, 32'h10, 32'h0, 0);
        op(1, 3'b010, 32'h10000, 32'h12345678, 0);
        op(1, 3'b100, 32'h10, 32'h0, 0);
        op(1, 3'b001, 32'h11, 32'hFFFF, 0);

        // Back-to-back loads with cpu_req held high.
        op(0, 3'b010, 32'h10, 32'h0, 1);
        op(0, 3'b010, 32'h14, 32'h0, 1);
        op(0, 3'b010, 32'h18, 32'h0, 0);

        // Randomized mix.
        for (int k = 0; k < 150; k++) begin
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                rf3 = 3'($urandom_range(0, 7));
            else if (rwe)
                rf3 = 3'($urandom_range(0, 2));
            else
                case ($urandom_range(0, 4))
                    0: rf3 = 3'd0;
                    1: rf3 = 3'd1;
                    2: rf3 = 3'd2;
                    3: rf3 = 3'd4;
                    default: rf3 = 3'd5;
                endcase
            low = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) begin
                if (rf3[1:0] == 2'b01) low[0] = 1'b0;
                if (rf3[1:0] == 2'b10) low = 2'b00;
            end
            if ($urandom_range(0, 9) == 0)
                ra = $urandom | 32'h0001_0000;
            else
                ra = {25'd0, 5'($urandom_range(0, 31)), low};
            op(rwe, rf3, ra, $urandom, 1'($urandom_range(0, 1)));
        end
        bus.cpu_req = 1'b0;

        // Reset in the WR cycle of an SB: no write, abort to IDLE.
        wait_ready();
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_funct3 = 3'b000;
        bus.cpu_addr   = 32'h21;
        bus.cpu_wdata  = 32'hAA;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.mem_write && t < 10);
        check("rmw_reached_wr", 32'(bus.mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_rmw_write", 32'(bus.mem_write), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(bus.cpu_ready), 32'd1);
        check("abort_done", 32'(bus.cpu_done), 32'd0);
        check("abort_err", 32'(bus.cpu_err), 32'd0);
        check("abort_rdata", bus.cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        op(0, 3'b010, 32'h20, 32'h0, 0);

        // Drain and final memory comparison.
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        @(negedge clk);
        for (int i = 0; i < MODEL_WORDS; i++)
            check($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
